// File: rtl/led_pkg.sv
// led_pkg: shared WS2812 definitions for led_string and led_string_rx.
// Contents: receiver state enum, 48 MHz WS2812 timing constants, colour word type.
package led_pkg;
  typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} rx_state_t;
  typedef logic [23:0] color_t;
  localparam int WS_T0H       = 19;
  localparam int WS_T1H       = 38;
  localparam int WS_BIT_CYC   = 60;
  localparam int WS_LATCH_CYC = 2400;
endpackage

// File: rtl/led_rx_sync.sv
// led_rx_sync: din synchronizer, optional majority glitch filter, rise/fall strobes.
// Ports: clk, reset (async active-low), din (async line) -> level (clean line),
//        rise/fall (one-cycle strobes on level edges).
// Macro LED_RX_GLITCH_FILTER_EN: adds a 3-sample majority filter (+1 cycle latency).
module led_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);
  logic s1, s2, prev;
`ifdef LED_RX_GLITCH_FILTER_EN
  logic s3, s4;
  always_ff @(posedge clk or negedge reset)
    if (!reset) {s1, s2, s3, s4, prev} <= '0;
    else {s1, s2, s3, s4, prev} <= {din, s1, s2, s3, level};
  // A lone one-cycle spike never occupies two of the three taps at once.
  assign level = (s2 & s3) | (s2 & s4) | (s3 & s4);
`else
  always_ff @(posedge clk or negedge reset)
    if (!reset) {s1, s2, prev} <= '0;
    else {s1, s2, prev} <= {din, s1, level};
  assign level = s2;
`endif
  assign rise = level & ~prev;
  assign fall = ~level & prev;
endmodule

// File: rtl/led_string_rx.sv
// led_string_rx: WS2812-style single-wire receiver assembling 24-bit colour words.
// Ports: clk, reset (async active-low), din (serial line) -> rgb/rgb_valid/pixel_idx
//        per word, frame_done/frame_pixels per latch gap, err pulse, busy level.
// Macro LED_RX_GLITCH_FILTER_EN: enables the majority glitch filter in led_rx_sync.
module led_string_rx import led_pkg::*; #(
  parameter int T1_MIN_CYC   = 29,
  parameter int HIGH_MIN_CYC = 6,
  parameter int HIGH_MAX_CYC = 50,
  parameter int LATCH_CYC    = WS_LATCH_CYC,
  parameter int CNT_W        = 12,
  parameter int PIX_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  output color_t           rgb,
  output logic             rgb_valid,
  output logic [PIX_W-1:0] pixel_idx,
  output logic             frame_done,
  output logic [PIX_W-1:0] frame_pixels,
  output logic             err,
  output logic             busy
);
  // cnt holds the number of samples seen in the current high/low run,
  // so the "last" values fire on the sample that reaches the limit.
  localparam logic [CNT_W-1:0] LAST_LO = CNT_W'(LATCH_CYC - 1);
  localparam logic [CNT_W-1:0] LAST_HI = CNT_W'(HIGH_MAX_CYC - 1);
  localparam logic [CNT_W-1:0] T1      = CNT_W'(T1_MIN_CYC);
  localparam logic [CNT_W-1:0] HMIN    = CNT_W'(HIGH_MIN_CYC);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  rx_state_t        state;
  logic             level, rise, fall;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       bit_cnt;
  logic [PIX_W-1:0] pix_cnt;
  color_t           sr, nxt_sr;
  led_rx_sync u_sync (.clk(clk), .reset(reset), .din(din), .level(level), .rise(rise), .fall(fall));
  assign nxt_sr = {sr[22:0], cnt >= T1};
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= SYNC;
      cnt          <= '0;
      bit_cnt      <= '0;
      pix_cnt      <= '0;
      sr           <= '0;
      rgb          <= '0;
      rgb_valid    <= 1'b0;
      pixel_idx    <= '0;
      frame_done   <= 1'b0;
      frame_pixels <= '0;
      err          <= 1'b0;
      busy         <= 1'b0;
    end else begin
      rgb_valid  <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
      case (state)
        SYNC:
          if (level) cnt <= '0;
          else if (cnt == LAST_LO) begin
            cnt   <= '0;
            state <= IDLE;
          end else cnt <= cnt + 1'b1;
        IDLE:
          if (rise) begin
            state   <= HIGH;
            cnt     <= ONE;
            bit_cnt <= '0;
            pix_cnt <= '0;
            busy    <= 1'b1;
          end
        HIGH:
          if (fall && cnt < HMIN || !fall && cnt == LAST_HI) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            cnt   <= '0;
            state <= SYNC;
          end else if (fall) begin
            sr    <= nxt_sr;
            cnt   <= ONE;
            state <= LOW;
            if (bit_cnt == 5'd23) begin
              rgb       <= nxt_sr;
              rgb_valid <= 1'b1;
              pixel_idx <= pix_cnt;
              pix_cnt   <= pix_cnt + 1'b1;
              bit_cnt   <= '0;
            end else bit_cnt <= bit_cnt + 1'b1;
          end else cnt <= cnt + 1'b1;
        LOW:
          if (rise) begin
            cnt   <= ONE;
            state <= HIGH;
          end else if (cnt == LAST_LO) begin
            // A frame ending mid-word drops the partial bits and flags it.
            frame_done   <= 1'b1;
            frame_pixels <= pix_cnt;
            err          <= bit_cnt != 5'd0;
            busy         <= 1'b0;
            cnt          <= '0;
            state        <= IDLE;
          end else cnt <= cnt + 1'b1;
        default: state <= SYNC;
      endcase
    end
  end
endmodule

// File: tb/tb_led_string_rx.sv
// tb_led_string_rx: directed self-checking bench for led_string_rx.
module tb_led_string_rx;
  import led_pkg::*;
`ifdef LED_RX_GLITCH_FILTER_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif
  logic clk = 1'b0, rst_n, din;
  color_t rgb;
  logic rgb_valid, frame_done, err, busy;
  logic [7:0] pixel_idx, frame_pixels;
  int total = 0, bad = 0, cyc = 0;
  int th0, th1, tl0, tl1, last_fall, rise_c;
  color_t v_rgb [256];
  int v_idx [256], v_cyc [256];
  int vcount = 0, fd_count = 0, fd_pixels = 0, fd_err = 0, err_count = 0, err_cyc = 0;

  led_string_rx dut (.clk(clk), .reset(rst_n), .din(din), .rgb(rgb), .rgb_valid(rgb_valid),
    .pixel_idx(pixel_idx), .frame_done(frame_done), .frame_pixels(frame_pixels), .err(err), .busy(busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rgb_valid && vcount < 256) begin
      v_rgb[vcount] = rgb;
      v_idx[vcount] = pixel_idx;
      v_cyc[vcount] = cyc;
      vcount++;
    end
    if (frame_done) begin
      fd_count++;
      fd_pixels = frame_pixels;
      fd_err = err;
    end
    if (err) begin
      err_count++;
      err_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_pulse(input int h, input int l);
    din = 1'b1;
    rise_c = cyc;
    wait_cyc(h);
    din = 1'b0;
    last_fall = cyc;
    wait_cyc(l);
  endtask

  task automatic send_bits(input color_t w, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) send_pulse(w[i] ? th1 : th0, w[i] ? tl1 : tl0);
  endtask

  task automatic set_timing(input int h0, input int h1, input int l0, input int l1);
    th0 = h0; th1 = h1; tl0 = l0; tl1 = l1;
  endtask

  initial begin
    int v0, e0, f0;
    rst_n = 1'b0;
    din = 1'b0;
    wait_cyc(5);
    chk("rst_rgb", rgb, 0);
    chk("rst_flags", {rgb_valid, frame_done, err, busy}, 0);
    chk("rst_idx", pixel_idx, 0);
    chk("rst_fpix", frame_pixels, 0);
    chk("rst_state", 32'(dut.state), 32'(SYNC));
    rst_n = 1'b1;
    wait_cyc(2410);

    set_timing(WS_T0H, WS_T1H, WS_BIT_CYC - WS_T0H, WS_BIT_CYC - WS_T1H);
    v0 = vcount;
    send_bits(24'h00CEFF, 23, 0);
    chk("n_busy_in", busy, 1);
    wait_cyc(2410);
    chk("n_cnt", vcount - v0, 1);
    chk("n_rgb", v_rgb[v0], 24'h00CEFF);
    chk("n_idx", v_idx[v0], 0);
    chk("n_lat", v_cyc[v0] - last_fall, LAT);
    chk("n_fd", fd_count, 1);
    chk("n_fpix", fd_pixels, 1);
    chk("n_err", err_count, 0);
    chk("n_busy_out", busy, 0);

    set_timing(6, 29, 2, 2);
    v0 = vcount;
    for (int w = 0; w < 144; w++) send_bits((w % 2 == 0) ? 24'h00CEFF : 24'h000000, 23, 0);
    wait_cyc(2410);
    chk("ff_cnt", vcount - v0, 144);
    for (int w = 0; w < 144 && v0 + w < vcount; w++) begin
      chk("ff_rgb", v_rgb[v0 + w], (w % 2 == 0) ? 24'h00CEFF : 24'h000000);
      chk("ff_idx", v_idx[v0 + w], w);
    end
    chk("ff_fpix", fd_pixels, 144);
    chk("ff_err", err_count, 0);

    set_timing(28, 29, 2, 2);
    send_bits(24'hA5C30F, 23, 0);
    wait_cyc(2410);
    chk("thr_rgb", rgb, 24'hA5C30F);
    chk("thr_fpix", fd_pixels, 1);
    chk("thr_err", err_count, 0);

    e0 = err_count;
    f0 = fd_count;
    send_pulse(5, 20);
    chk("p5_err", err_count, e0 + 1);
    chk("p5_busy", busy, 0);
    wait_cyc(2410);
    set_timing(6, 29, 2, 2);
    send_bits(24'h123456, 23, 0);
    wait_cyc(2410);
    chk("p5_rec_rgb", rgb, 24'h123456);
    chk("p5_rec_fd", fd_count, f0 + 1);

    e0 = err_count;
    f0 = fd_count;
    din = 1'b1;
    rise_c = cyc;
    wait_cyc(60);
    din = 1'b0;
    wait_cyc(2410);
    chk("hmax_err", err_count, e0 + 1);
    chk("hmax_when", err_cyc - rise_c, LAT + 49);
    chk("hmax_nofd", fd_count, f0);
    send_bits(24'h0F0F0F, 23, 0);
    wait_cyc(2410);
    chk("hmax_rec_rgb", rgb, 24'h0F0F0F);
    chk("hmax_rec_fpix", fd_pixels, 1);

    e0 = err_count;
    f0 = fd_count;
    v0 = vcount;
    send_bits(24'hFFFFFF, 23, 14);
    wait_cyc(2410);
    chk("part_fd", fd_count, f0 + 1);
    chk("part_err_same", fd_err, 1);
    chk("part_err", err_count, e0 + 1);
    chk("part_fpix", fd_pixels, 0);
    chk("part_rgb", rgb, 24'h0F0F0F);
    chk("part_nov", vcount, v0);

    send_bits(24'hAAAAAA, 23, 13);
    din = 1'b1;
    wait_cyc(10);
    chk("mid_busy_pre", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rgb", rgb, 0);
    chk("mid_flags", {rgb_valid, frame_done, err, busy}, 0);
    chk("mid_idx_fpix", {pixel_idx, frame_pixels}, 0);
    chk("mid_state", 32'(dut.state), 32'(SYNC));
    wait_cyc(3);
    din = 1'b0;
    rst_n = 1'b1;
    v0 = vcount;
    f0 = fd_count;
    e0 = err_count;
    send_bits(24'h111111, 23, 0);
    wait_cyc(2410);
    chk("mid_ign_v", vcount, v0);
    chk("mid_ign_fd", fd_count, f0);
    chk("mid_ign_err", err_count, e0);
    send_bits(24'h5A5A5A, 23, 0);
    wait_cyc(2410);
    chk("mid_rec_rgb", rgb, 24'h5A5A5A);
    chk("mid_rec_idx", pixel_idx, 0);
    chk("mid_rec_fpix", fd_pixels, 1);
    chk("mid_rec_fd", fd_count, f0 + 1);

`ifdef LED_RX_GLITCH_FILTER_EN
    e0 = err_count;
    v0 = vcount;
    send_bits(24'hC3A5F0, 23, 12);
    wait_cyc(5);
    din = 1'b1;
    wait_cyc(1);
    din = 1'b0;
    wait_cyc(5);
    send_bits(24'hC3A5F0, 11, 0);
    wait_cyc(2410);
    chk("glf_err", err_count, e0);
    chk("glf_cnt", vcount - v0, 1);
    chk("glf_rgb", rgb, 24'hC3A5F0);
    chk("glf_fpix", fd_pixels, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
